melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Plays a melody stored in a synchronous ROM. Each ROM entry is a pair {note, duration}.
- For each note, the block drives the tone-generator note code and uses the shared delay block to time how long the note lasts.
- It sits between the melody ROM, the delay instance and the tone generator in the music top level.
- It is the only block that drives the delay's duration and enabled inputs.

Parameters:
- ADDR_W, 6, ROM address width; the melody holds at most 2^ADDR_W entries.
- NOTE_W, 6, note code width; code 0 means rest.
- DUR_W, 11, duration width; must match the delay block's duration input.
- GAP_CYCLES, 4, number of clk cycles with the tone muted between consecutive notes (articulation gap); must be at least 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; starts playback at address 0 when in IDLE or DONE.
- stop  in  1  level; aborts playback and returns to IDLE.
- loop  in  1  level; when high at end-of-song, playback restarts at address 0 instead of going to DONE.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  NOTE_W+DUR_W  {note[NOTE_W-1:0], duration[DUR_W-1:0]}; valid 1 cycle after rom_addr.
- dly_duration  out  DUR_W  duration driven to the delay block.
- dly_enabled  out  1  enable driven to the delay block.
- dly_active  in  1  delay busy flag; high while the programmed duration is running.
- note_code  out  NOTE_W  code sent to the tone generator.
- note_on  out  1  tone generator gate.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset values (asynchronous, while rst_n is low): state=IDLE; rom_addr=0; dly_duration=0; dly_enabled=0; note_code=0; note_on=0; busy=0; done=0; gap counter=0.
- States: IDLE, FETCH, LATCH, ARM, PLAY, GAP, DONE.
- IDLE: outputs are quiet. On start: rom_addr<=0, go to FETCH.
- FETCH: one cycle for the ROM read latency, then LATCH.
- LATCH: sample rom_data.
  - duration==0 is the end-of-song marker. If loop=1: rom_addr<=0, go to FETCH. Otherwise go to DONE.
  - Otherwise: dly_duration<=duration; note_code<=note; note_on<=(note!=0); dly_enabled<=1; go to ARM.
- ARM: wait for dly_active=1, then go to PLAY.
  - A delay that never asserts active is a system fault. It is handled only by stop.
- PLAY: hold dly_enabled=1 and hold the note.
  - When dly_active falls to 0: note_on<=0; dly_enabled<=0; load the gap counter with GAP_CYCLES-1; go to GAP.
- GAP: decrement the gap counter each cycle. At 0:
  - If rom_addr is at its maximum: the end of the ROM is an implicit end-of-song, handled with the same loop/DONE rule as LATCH.
  - Otherwise: rom_addr<=rom_addr+1, go to FETCH.
  - The dly_enabled low time equals GAP_CYCLES+2 cycles, which re-arms the delay.
- DONE: done=1. On start: go to FETCH with rom_addr=0.
- Latency: from a start pulse to note_on high is 3 cycles (FETCH, LATCH, register).
- Note length: note_on stays high for the delay active period plus the ARM wait.
- stop has priority over every other transition. In any state, one cycle after stop: note_on=0, dly_enabled=0, state=IDLE, rom_addr=0. A start in the same cycle as stop is ignored.
- start while busy is ignored; there is no restart mid-song.
- Rest (note=0): timed exactly like a note, with note_on held low.
- Reset mid-note: all outputs go to their reset values immediately, independent of clk.
- Address arithmetic: ADDR_W-bit unsigned; the address never wraps silently past the maximum.
- Width rules: no widening or truncation of duration; it passes through at DUR_W bits.

Decomposition:
- Shared package/header music_pkg: state encodings, NOTE_REST=0, END_MARK=0 duration constant, and the default NOTE_W/DUR_W values.
- Delay and tone blocks are instantiated at the top level, not inside this block.
- One sub-module, seq_gap_counter: a loadable down-counter with a zero flag, used for the GAP state. Everything else is a single FSM.

Test Plan:
- Bench model: behavioural ROM with 1-cycle read latency and a delay model (active high for duration×2 cycles after the enabled rising edge). Entries: {5,3}, {0,2}, {9,1}, {x,0}.
- Reset then start (loop=0) -> note_code=5, note_on 3 cycles after start; then a rest with note_on=0 for the second entry; then note_code=9; then done=1, busy=0, with rom_addr reaching 3.
- Same ROM with loop=1 -> after the end marker, rom_addr returns to 0 and note_code=5 replays; done is never asserted.
- stop asserted mid-PLAY of the second note -> the next cycle shows note_on=0, dly_enabled=0, state IDLE; a later start replays from address 0.
- rst_n pulsed low mid-PLAY, between clock edges -> all outputs drop to 0 asynchronously; a start after release plays normally.
- ROM completely filled with nonzero durations (64 entries) -> after entry 63, DONE with no address wrap; dly_enabled low for GAP_CYCLES+2 cycles between every pair of notes.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the music subsystem: default widths, marker codes
// and the melody sequencer state encoding.
package music_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned NOTE_W_DEF = 6;
  localparam int unsigned DUR_W_DEF  = 11;

  localparam int unsigned NOTE_REST = 0;
  localparam int unsigned END_MARK  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ARM,
    S_PLAY,
    S_GAP,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/melody_sequencer_if.sv
// Bus between the melody sequencer and its ROM, delay block and tone generator.
interface melody_sequencer_if #(
  parameter int unsigned ADDR_W = music_pkg::ADDR_W_DEF,
  parameter int unsigned NOTE_W = music_pkg::NOTE_W_DEF,
  parameter int unsigned DUR_W  = music_pkg::DUR_W_DEF
);

  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [DUR_W-1:0]        dly_duration;
  logic                    dly_enabled;
  logic                    dly_active;
  logic [NOTE_W-1:0]       note_code;
  logic                    note_on;

  modport master (
    output rom_addr,
    input  rom_data,
    output dly_duration,
    output dly_enabled,
    input  dly_active,
    output note_code,
    output note_on
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  dly_duration,
    input  dly_enabled,
    output dly_active,
    input  note_code,
    input  note_on
  );

endinterface

// File: rtl/seq_gap_counter.sv
// Loadable down-counter with zero flag; times the muted gap between notes.
module seq_gap_counter #(
  parameter int unsigned W = 2
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  always_comb begin
    zero = (count == '0);
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through {note, duration} ROM entries, gating the tone generator and
// timing each note with the shared delay block.
module melody_sequencer
  import music_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned NOTE_W     = NOTE_W_DEF,
  parameter int unsigned DUR_W      = DUR_W_DEF,
  parameter int unsigned GAP_CYCLES = 4
)(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic loop,
  melody_sequencer_if.master bus,
  output logic busy,
  output logic done
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_t        state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DUR_W-1:0]  dur_q, dur_nx;
  logic [NOTE_W-1:0] code_q, code_nx;
  logic              en_q, en_nx;
  logic              on_q, on_nx;

  logic              gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0]  gap_count;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  always_comb begin
    rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
    rom_dur  = bus.rom_data[DUR_W-1:0];
  end

  seq_gap_counter #(
    .W (GAP_W)
  ) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_CYCLES - 1)),
    .dec      (gap_dec),
    .count    (gap_count),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      dur_q  <= '0;
      code_q <= '0;
      en_q   <= 1'b0;
      on_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      addr_q <= addr_nx;
      dur_q  <= dur_nx;
      code_q <= code_nx;
      en_q   <= en_nx;
      on_q   <= on_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    dur_nx   = dur_q;
    code_nx  = code_q;
    en_nx    = en_q;
    on_nx    = on_q;
    gap_load = 1'b0;
    gap_dec  = 1'b0;

    // stop outranks every state transition, including a coincident start
    if (stop) begin
      state_nx = S_IDLE;
      addr_nx  = '0;
      dur_nx   = '0;
      code_nx  = '0;
      en_nx    = 1'b0;
      on_nx    = 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr_nx  = '0;
            state_nx = S_FETCH;
          end
        end
        S_FETCH: state_nx = S_LATCH;
        S_LATCH: begin
          if (rom_dur == DUR_W'(END_MARK)) begin
            if (loop) begin
              addr_nx  = '0;
              state_nx = S_FETCH;
            end else begin
              state_nx = S_DONE;
            end
          end else begin
            dur_nx   = rom_dur;
            code_nx  = rom_note;
            on_nx    = (rom_note != NOTE_W'(NOTE_REST));
            en_nx    = 1'b1;
            state_nx = S_ARM;
          end
        end
        S_ARM: begin
          if (bus.dly_active) state_nx = S_PLAY;
        end
        S_PLAY: begin
          if (!bus.dly_active) begin
            on_nx    = 1'b0;
            en_nx    = 1'b0;
            gap_load = 1'b1;
            state_nx = S_GAP;
          end
        end
        S_GAP: begin
          if (!gap_zero) begin
            gap_dec = 1'b1;
          end else if (addr_q == '1) begin
            // last ROM slot acts as an implicit end marker; no wrap
            if (loop) begin
              addr_nx  = '0;
              state_nx = S_FETCH;
            end else begin
              state_nx = S_DONE;
            end
          end else begin
            addr_nx  = addr_q + 1'b1;
            state_nx = S_FETCH;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  assign bus.rom_addr     = addr_q;
  assign bus.dly_duration = dur_q;
  assign bus.dly_enabled  = en_q;
  assign bus.note_code    = code_q;
  assign bus.note_on      = on_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with behavioural ROM and delay models.
module tb_melody_sequencer;

  localparam int ADDR_W     = 6;
  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 11;
  localparam int GAP_CYCLES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic loop  = 1'b0;
  logic busy, done;

  int errors = 0;
  int checks = 0;

  logic [NOTE_W+DUR_W-1:0] rom [64];
  int   dcnt;
  logic en_prev;

  melody_sequencer_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus_if ();

  melody_sequencer #(
    .ADDR_W     (ADDR_W),
    .NOTE_W     (NOTE_W),
    .DUR_W      (DUR_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .loop  (loop),
    .bus   (bus_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // ROM with one cycle of read latency
  always @(posedge clk) bus_if.rom_data <= rom[bus_if.rom_addr];

  // Delay: active for duration*2 cycles after each rising edge of enabled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt    <= 0;
      en_prev <= 1'b0;
    end else begin
      en_prev <= bus_if.dly_enabled;
      if (bus_if.dly_enabled && !en_prev) dcnt <= 2 * int'(bus_if.dly_duration);
      else if (dcnt > 0) dcnt <= dcnt - 1;
    end
  end
  assign bus_if.dly_active = (dcnt != 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_song();
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom[0] = {6'd5, 11'd3};
    rom[1] = {6'd0, 11'd2};
    rom[2] = {6'd9, 11'd1};
    rom[3] = {6'd33, 11'd0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus_if.rom_addr, bus_if.dly_duration, bus_if.dly_enabled, bus_if.note_code,
         bus_if.note_on, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d dur=%0d en=%0b code=%0d on=%0b busy=%0b done=%0b, all required 0",
               bus_if.rom_addr, bus_if.dly_duration, bus_if.dly_enabled, bus_if.note_code,
               bus_if.note_on, busy, done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int hi, lo;
    logic rest_bad;
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_fetch: got %0b want 1", busy); end
    tick();
    checks++;
    if (bus_if.note_on !== 1'b0) begin errors++; $display("FAIL basic_on_early: got %0b want 0", bus_if.note_on); end
    tick();
    checks++;
    if ({bus_if.note_on, bus_if.dly_enabled, bus_if.note_code, bus_if.dly_duration} !== {1'b1, 1'b1, 6'd5, 11'd3}) begin
      errors++;
      $display("FAIL basic_note1: on=%0b en=%0b code=%0d dur=%0d want 1 1 5 3",
               bus_if.note_on, bus_if.dly_enabled, bus_if.note_code, bus_if.dly_duration);
    end
    hi = 0;
    for (int i = 0; i < 50 && bus_if.note_on; i++) begin hi++; tick(); end
    checks++;
    if (hi !== 8) begin errors++; $display("FAIL basic_note1_len: got %0d want 8", hi); end
    lo = 0;
    for (int i = 0; i < 50 && !bus_if.dly_enabled; i++) begin lo++; tick(); end
    checks++;
    if (lo !== GAP_CYCLES + 2) begin errors++; $display("FAIL basic_gap1: got %0d want %0d", lo, GAP_CYCLES + 2); end
    checks++;
    if ({bus_if.note_on, bus_if.note_code, bus_if.dly_duration, bus_if.rom_addr} !== {1'b0, 6'd0, 11'd2, 6'd1}) begin
      errors++;
      $display("FAIL basic_rest: on=%0b code=%0d dur=%0d addr=%0d want 0 0 2 1",
               bus_if.note_on, bus_if.note_code, bus_if.dly_duration, bus_if.rom_addr);
    end
    hi = 0;
    rest_bad = 1'b0;
    for (int i = 0; i < 50 && bus_if.dly_enabled; i++) begin
      if (bus_if.note_on) rest_bad = 1'b1;
      hi++;
      tick();
    end
    checks++;
    if (hi !== 6) begin errors++; $display("FAIL basic_rest_len: got %0d want 6", hi); end
    checks++;
    if (rest_bad !== 1'b0) begin errors++; $display("FAIL basic_rest_silent: got %0b want 0", rest_bad); end
    lo = 0;
    for (int i = 0; i < 50 && !bus_if.dly_enabled; i++) begin lo++; tick(); end
    checks++;
    if (lo !== GAP_CYCLES + 2) begin errors++; $display("FAIL basic_gap2: got %0d want %0d", lo, GAP_CYCLES + 2); end
    checks++;
    if ({bus_if.note_on, bus_if.note_code, bus_if.dly_duration, bus_if.rom_addr} !== {1'b1, 6'd9, 11'd1, 6'd2}) begin
      errors++;
      $display("FAIL basic_note3: on=%0b code=%0d dur=%0d addr=%0d want 1 9 1 2",
               bus_if.note_on, bus_if.note_code, bus_if.dly_duration, bus_if.rom_addr);
    end
    for (int i = 0; i < 50 && !done; i++) tick();
    checks++;
    if ({done, busy, bus_if.note_on, bus_if.dly_enabled, bus_if.rom_addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd3}) begin
      errors++;
      $display("FAIL basic_done: done=%0b busy=%0b on=%0b en=%0b addr=%0d want 1 0 0 0 3",
               done, busy, bus_if.note_on, bus_if.dly_enabled, bus_if.rom_addr);
    end
  endtask

  task automatic test_loop();
    logic done_seen, saw3, found;
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 1'b0;
    saw3 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) done_seen = 1'b1;
      if (bus_if.rom_addr == 6'd3) saw3 = 1'b1;
      if (saw3 && bus_if.dly_enabled) begin found = 1'b1; break; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL loop_replay_seen: got %0b want 1", found); end
    checks++;
    if ({bus_if.note_code, bus_if.rom_addr, bus_if.note_on, busy} !== {6'd5, 6'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL loop_replay: code=%0d addr=%0d on=%0b busy=%0b want 5 0 1 1",
               bus_if.note_code, bus_if.rom_addr, bus_if.note_on, busy);
    end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("FAIL loop_no_done: got %0b want 0", done_seen); end
    stop = 1'b1;
    loop = 1'b0;
    tick();
    stop = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL loop_stop_idle: busy=%0b done=%0b want 0 0", busy, done); end
    repeat (20) tick();
  endtask

  task automatic test_stop();
    logic found;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus_if.rom_addr == 6'd1 && bus_if.dly_enabled) begin found = 1'b1; break; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL stop_reach_note2: got %0b want 1", found); end
    tick();
    tick();
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    checks++;
    if ({bus_if.note_on, bus_if.dly_enabled, busy, done, bus_if.rom_addr} !== {1'b0, 1'b0, 1'b0, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL stop_idle: on=%0b en=%0b busy=%0b done=%0b addr=%0d want 0 0 0 0 0",
               bus_if.note_on, bus_if.dly_enabled, busy, done, bus_if.rom_addr);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_start_ignored: busy=%0b want 0", busy); end
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus_if.note_on, bus_if.note_code, bus_if.rom_addr} !== {1'b1, 6'd5, 6'd0}) begin
      errors++;
      $display("FAIL stop_restart: on=%0b code=%0d addr=%0d want 1 5 0",
               bus_if.note_on, bus_if.note_code, bus_if.rom_addr);
    end
    tick();
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({bus_if.note_on, bus_if.dly_enabled, busy} !== 3'b000) begin
      errors++;
      $display("FAIL stop_sounding: on=%0b en=%0b busy=%0b want 0 0 0", bus_if.note_on, bus_if.dly_enabled, busy);
    end
    repeat (20) tick();
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if ({bus_if.note_on, bus_if.dly_enabled} !== 2'b11) begin
      errors++;
      $display("FAIL areset_pre: on=%0b en=%0b want 1 1", bus_if.note_on, bus_if.dly_enabled);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.rom_addr, bus_if.dly_duration, bus_if.dly_enabled, bus_if.note_code,
         bus_if.note_on, busy, done} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: addr=%0d dur=%0d en=%0b code=%0d on=%0b busy=%0b done=%0b, all required 0",
               bus_if.rom_addr, bus_if.dly_duration, bus_if.dly_enabled, bus_if.note_code,
               bus_if.note_on, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus_if.note_on, bus_if.note_code, bus_if.dly_enabled} !== {1'b1, 6'd5, 1'b1}) begin
      errors++;
      $display("FAIL areset_replay: on=%0b code=%0d en=%0b want 1 5 1",
               bus_if.note_on, bus_if.note_code, bus_if.dly_enabled);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_full_rom();
    int rises, lo, bad_gap, bad_code;
    logic wrapped, prev_en;
    logic [ADDR_W-1:0] prev_addr;
    logic [NOTE_W-1:0] n;
    for (int i = 0; i < 64; i++) begin
      n = NOTE_W'((i % 63) + 1);
      rom[i] = {n, 11'd1};
    end
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    rises = 0; lo = 0; bad_gap = 0; bad_code = 0;
    wrapped = 1'b0; prev_en = 1'b0; prev_addr = '0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      if (bus_if.dly_enabled && !prev_en) begin
        n = NOTE_W'((rises % 63) + 1);
        if (rises > 0 && lo != GAP_CYCLES + 2) bad_gap++;
        if (bus_if.note_code != n) bad_code++;
        rises++;
        lo = 0;
      end else if (!bus_if.dly_enabled) begin
        lo++;
      end
      if (bus_if.rom_addr < prev_addr) wrapped = 1'b1;
      prev_en = bus_if.dly_enabled;
      prev_addr = bus_if.rom_addr;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %0b want 1", done); end
    checks++;
    if (rises !== 64) begin errors++; $display("FAIL full_note_count: got %0d want 64", rises); end
    checks++;
    if (bad_gap !== 0) begin errors++; $display("FAIL full_gaps: bad=%0d want 0", bad_gap); end
    checks++;
    if (bad_code !== 0) begin errors++; $display("FAIL full_codes: bad=%0d want 0", bad_code); end
    checks++;
    if (wrapped !== 1'b0) begin errors++; $display("FAIL full_no_wrap: got %0b want 0", wrapped); end
    repeat (5) tick();
    checks++;
    if ({bus_if.rom_addr, done, busy} !== {6'd63, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_final: addr=%0d done=%0b busy=%0b want 63 1 0", bus_if.rom_addr, done, busy);
    end
  endtask

  initial begin
    load_song();
    test_reset();
    test_basic();
    test_loop();
    test_stop();
    test_async_reset();
    test_full_rom();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
